// File: rtl/msk_pre_inv_sbox_seq.sv
// msk_pre_inv_sbox_seq: masked linear pre-layer for the inverse sbox, with a pin FIFO that re-aligns with the sbox output
module msk_pre_inv_sbox_seq #(
  parameter int d = 4,
  parameter int NBITS = 4,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NBITS*d-1:0] in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [NBITS*d-1:0] sb_data,
  output logic               sb_valid,
  input  logic               sb_ready,
  output logic [2*d-1:0]     p_data,
  output logic               p_valid,
  input  logic               p_ready,
  output logic [CW-1:0]      p_count,
  output logic               underflow
);
  logic [d-1:0] x0, x1, x2, x3;
  logic [NBITS*d-1:0] lin_s;
  logic [2*d-1:0] st_p;
  logic [2*d-1:0] mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic st_v, push, pop, load;
  assign x0 = in_data[0 +: d];
  assign x1 = in_data[d +: d];
  assign x2 = in_data[2*d +: d];
  assign x3 = in_data[3*d +: d];
  assign lin_s = {x2 ^ x3, x3, x1, x0 ^ x2};
  assign sb_valid = st_v & (p_count != CW'(DEPTH));
  assign push = sb_valid & sb_ready;
  assign in_ready = !st_v | push;
  assign load = in_valid & in_ready;
  assign p_valid = p_count != '0;
  assign pop = p_valid & p_ready;
  assign p_data = p_valid ? mem[rptr] : '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st_v <= 1'b0;
      sb_data <= '0;
      st_p <= '0;
      wptr <= '0;
      rptr <= '0;
      p_count <= '0;
      underflow <= 1'b0;
    end else begin
      if (load) begin
        st_v <= 1'b1;
        sb_data <= lin_s;
        st_p <= {x1, x0};
      end else if (push)
        st_v <= 1'b0;
      if (push) wptr <= (wptr == PW'(DEPTH - 1)) ? '0 : wptr + 1'b1;
      if (pop) rptr <= (rptr == PW'(DEPTH - 1)) ? '0 : rptr + 1'b1;
      if (push != pop) p_count <= push ? p_count + 1'b1 : p_count - 1'b1;
      if (p_ready & !p_valid) underflow <= 1'b1;
    end
  always_ff @(posedge clk)
    if (push) mem[wptr] <= st_p;
endmodule
